// File: rtl/spi_slave_register_bank.sv
// spi_slave_register_bank
//   SPI slave (all four CPOL/CPHA modes) in front of a local register file.
//   serial_clock, chip_select and serial_in are oversampled on clock; there
//   are no flops clocked by serial_clock.
//
//   Frame, MSB first: rw (1 = read), ADDRESS_WIDTH address bits, then any
//   number of DATA_WIDTH-bit data words with auto-incrementing index.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   clock_polarity/phase  CPOL / CPHA, static while chip_select is low
//   serial_clock          SPI clock from the master (asynchronous)
//   chip_select           active-low slave select (asynchronous)
//   serial_in/serial_out  MOSI / MISO
//   host_*                parallel host port; host_read_data has 1-cycle latency
//   write_strobe          one-cycle pulse per committed SPI word, with
//                         write_address / write_data valid in the same cycle
//   frame_active          high while a frame is in progress
//   frame_error           one-cycle pulse on a truncated header or data word
//   word_count            data words completed in the current/last frame
//   debug_state           current FSM state (IDLE=0, HEADER=1, DATA=2)
//
// Handshake: write_strobe is a valid-only pulse with no back-pressure; the
// register file commits the word in the same cycle the strobe is high, and
// consumers must take write_address/write_data in that cycle.
module spi_slave_register_bank #(
  parameter int DATA_WIDTH           = 16,
  parameter int ADDRESS_WIDTH        = 15,
  parameter int MEMORY_ADDRESS_WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clock_polarity,
  input  logic                            clock_phase,
  input  logic                            serial_clock,
  input  logic                            chip_select,
  input  logic                            serial_in,
  output logic                            serial_out,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] host_address,
  input  logic                            host_write_enable,
  input  logic [DATA_WIDTH-1:0]           host_write_data,
  output logic [DATA_WIDTH-1:0]           host_read_data,
  output logic                            write_strobe,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]           write_data,
  output logic                            frame_active,
  output logic                            frame_error,
  output logic [15:0]                     word_count,
  output logic [1:0]                      debug_state
);

  localparam int DEPTH = 1 << MEMORY_ADDRESS_WIDTH;
  localparam int MAXB  = (ADDRESS_WIDTH + 1 > DATA_WIDTH) ? ADDRESS_WIDTH + 1 : DATA_WIDTH;
  localparam int CW    = $clog2(MAXB + 1);
  localparam int TCW   = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HEADER = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;

  // [0] first stage, [1] synchronised value, [2] previous synchronised value
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] sin_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_q <= {3{clock_polarity}};
      cs_q   <= 3'b111;
      sin_q  <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], serial_clock};
      cs_q   <= {cs_q[1:0], chip_select};
      sin_q  <= {sin_q[0], serial_in};
    end
  end

  logic sclk_rise, sclk_fall, leading_edge, trailing_edge;
  logic sample_edge, drive_edge, cs_fall, cs_rise, sin;

  assign sclk_rise     = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall     = ~sclk_q[1] & sclk_q[2];
  assign leading_edge  = clock_polarity ? sclk_fall : sclk_rise;
  assign trailing_edge = clock_polarity ? sclk_rise : sclk_fall;
  assign sample_edge   = clock_phase ? trailing_edge : leading_edge;
  assign drive_edge    = clock_phase ? leading_edge : trailing_edge;
  assign cs_fall       = ~cs_q[1] & cs_q[2];
  assign cs_rise       = cs_q[1] & ~cs_q[2];
  assign sin           = sin_q[1];

  logic [DATA_WIDTH-1:0]           mem [0:DEPTH-1];
  logic [1:0]                      state;
  logic [CW-1:0]                   bit_count;
  logic [TCW-1:0]                  tx_count;
  logic [ADDRESS_WIDTH-1:0]        hdr_shift;
  logic [DATA_WIDTH-2:0]           rx_shift;
  logic [DATA_WIDTH-1:0]           tx_shift;
  logic [MEMORY_ADDRESS_WIDTH-1:0] index;
  logic                            rw;
  logic                            load_pending;

  logic [ADDRESS_WIDTH:0]  header_word;
  logic [DATA_WIDTH-1:0]   rx_word;
  assign header_word = {hdr_shift, sin};
  assign rx_word     = {rx_shift, sin};
  assign debug_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bit_count     <= '0;
      tx_count      <= '0;
      hdr_shift     <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      index         <= '0;
      rw            <= 1'b0;
      load_pending  <= 1'b0;
      serial_out    <= 1'b0;
      write_strobe  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      frame_active  <= 1'b0;
      frame_error   <= 1'b0;
      word_count    <= '0;
    end else begin
      write_strobe <= 1'b0;
      frame_error  <= 1'b0;
      load_pending <= 1'b0;
      // Prefetch the next read word; index was already advanced.
      if (load_pending) tx_shift <= mem[index];
      if (cs_rise) begin
        state        <= IDLE;
        frame_active <= 1'b0;
        serial_out   <= 1'b0;
        if (state == HEADER || (state == DATA && bit_count != '0)) frame_error <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state        <= HEADER;
              frame_active <= 1'b1;
              bit_count    <= '0;
              tx_count     <= '0;
              word_count   <= '0;
              serial_out   <= 1'b0;
            end
          end
          HEADER: begin
            if (sample_edge) begin
              hdr_shift <= header_word[ADDRESS_WIDTH-1:0];
              if (bit_count == CW'(ADDRESS_WIDTH)) begin
                state        <= DATA;
                bit_count    <= '0;
                rw           <= header_word[ADDRESS_WIDTH];
                index        <= header_word[MEMORY_ADDRESS_WIDTH-1:0];
                load_pending <= header_word[ADDRESS_WIDTH];
              end else begin
                bit_count <= bit_count + CW'(1);
              end
            end
          end
          DATA: begin
            if (sample_edge) begin
              rx_shift <= rx_word[DATA_WIDTH-2:0];
              if (bit_count == CW'(DATA_WIDTH - 1)) begin
                bit_count  <= '0;
                word_count <= word_count + 16'd1;
                if (!rw) begin
                  write_strobe  <= 1'b1;
                  write_address <= index;
                  write_data    <= rx_word;
                  index         <= index + MEMORY_ADDRESS_WIDTH'(1);
                end
              end else begin
                bit_count <= bit_count + CW'(1);
              end
            end
            // Drive and sample edges never coincide, and the prefetch lands
            // several cycles before the next drive edge.
            if (drive_edge && rw) begin
              serial_out <= tx_shift[DATA_WIDTH-1];
              tx_shift   <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              if (tx_count == TCW'(DATA_WIDTH - 1)) begin
                tx_count     <= '0;
                index        <= index + MEMORY_ADDRESS_WIDTH'(1);
                load_pending <= 1'b1;
              end else begin
                tx_count <= tx_count + TCW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Register file: an SPI commit wins over a same-index host write.
  always_ff @(posedge clock) begin
    if (host_write_enable && !(write_strobe && host_address == write_address))
      mem[host_address] <= host_write_data;
    if (write_strobe)
      mem[write_address] <= write_data;
  end

  always_ff @(posedge clock) begin
    if (reset) host_read_data <= '0;
    else       host_read_data <= mem[host_address];
  end

endmodule

// File: tb/tb_spi_slave_register_bank.sv
// Testbench for spi_slave_register_bank: a bit-banged SPI master drives
// frames in all four modes; expected commits and read words come from a
// plain array model of the register file and are queued for a monitor.
module tb_spi_slave_register_bank;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int MAW = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic cpol, cpha, sclk, cs, mosi;
  logic serial_out;
  logic [MAW-1:0] host_address;
  logic host_write_enable;
  logic [DW-1:0] host_write_data, host_read_data;
  logic write_strobe;
  logic [MAW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic frame_active, frame_error;
  logic [15:0] word_count;
  logic [1:0] debug_state;

  spi_slave_register_bank #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEMORY_ADDRESS_WIDTH(MAW)) dut (
    .clock(clock), .reset(reset), .clock_polarity(cpol), .clock_phase(cpha),
    .serial_clock(sclk), .chip_select(cs), .serial_in(mosi), .serial_out(serial_out),
    .host_address(host_address), .host_write_enable(host_write_enable),
    .host_write_data(host_write_data), .host_read_data(host_read_data),
    .write_strobe(write_strobe), .write_address(write_address), .write_data(write_data),
    .frame_active(frame_active), .frame_error(frame_error), .word_count(word_count),
    .debug_state(debug_state)
  );

  int total = 0;
  int bad = 0;
  int half = 4;
  int err_seen = 0;
  int strobe_seen = 0;
  logic [DW-1:0] ref_mem [256];
  logic [MAW+DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] got_rd_q[$];
  logic [DW-1:0] tx_words[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_error) err_seen++;
      if (write_strobe) begin
        strobe_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit: got %h expected none", {write_address, write_data});
        end else begin
          check("commit", {write_address, write_data}, exp_q.pop_front());
        end
      end
      if (got_rd_q.size() > 0) begin
        if (exp_rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read_word: got %h expected none", got_rd_q.pop_front());
        end else begin
          check("read_word", got_rd_q.pop_front(), exp_rd_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    @(negedge clock);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    wait_cycles(6);
  endtask

  task automatic spi_frame(input logic rw, input logic [AW-1:0] addr, input int nbits,
                           output int quiet_ones);
    logic b[$];
    logic [DW-1:0] cur;
    logic bitv;
    quiet_ones = 0;
    cur = '0;
    b.push_back(rw);
    for (int i = AW - 1; i >= 0; i--) b.push_back(addr[i]);
    foreach (tx_words[k]) for (int j = DW - 1; j >= 0; j--) b.push_back(tx_words[k][j]);
    @(negedge clock);
    cs = 1'b0;
    wait_cycles(half);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = b[i];
        wait_cycles(half);
        bitv = serial_out;
        sclk = ~sclk;
        wait_cycles(half);
        sclk = ~sclk;
      end else begin
        wait_cycles(half);
        sclk = ~sclk;
        mosi = b[i];
        wait_cycles(half);
        bitv = serial_out;
        sclk = ~sclk;
      end
      if (i == 8) check("frame_active_mid", {31'd0, frame_active}, 32'd1);
      if (i <= AW || !rw) quiet_ones += int'(bitv);
      else begin
        cur = {cur[DW-2:0], bitv};
        if ((i - AW - 1) % DW == DW - 1) got_rd_q.push_back(cur);
      end
    end
    wait_cycles(half);
    cs = 1'b1;
    wait_cycles(10);
  endtask

  task automatic run_write(input logic pol, input logic pha, input logic [AW-1:0] addr);
    logic [7:0] idx;
    int q;
    int n;
    n = tx_words.size();
    idx = addr[7:0];
    set_mode(pol, pha);
    foreach (tx_words[k]) begin
      exp_q.push_back({idx, tx_words[k]});
      ref_mem[idx] = tx_words[k];
      idx++;
    end
    spi_frame(1'b0, addr, AW + 1 + n * DW, q);
    check("write_miso_quiet", q, 0);
    check("word_count_write", {16'd0, word_count}, n);
    check("frame_active_after", {31'd0, frame_active}, 32'd0);
  endtask

  task automatic run_read(input logic pol, input logic pha, input logic [AW-1:0] addr, input int n);
    logic [7:0] idx;
    int q;
    idx = addr[7:0];
    set_mode(pol, pha);
    tx_words.delete();
    repeat (n) tx_words.push_back(16'($urandom));
    for (int k = 0; k < n; k++) begin
      exp_rd_q.push_back(ref_mem[idx]);
      idx++;
    end
    spi_frame(1'b1, addr, AW + 1 + n * DW, q);
    check("header_miso_quiet", q, 0);
    check("word_count_read", {16'd0, word_count}, n);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    host_address = a;
    host_write_data = d;
    host_write_enable = 1'b1;
    @(negedge clock);
    host_write_enable = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_check(input logic [7:0] a);
    @(negedge clock);
    host_address = a;
    @(negedge clock);
    check("host_read", {16'd0, host_read_data}, {16'd0, ref_mem[a]});
  endtask

  task automatic collide(input logic [7:0] hidx);
    int q;
    int waited;
    set_mode(1'b0, 1'b0);
    tx_words = '{16'hAAAA};
    exp_q.push_back({8'h10, 16'hAAAA});
    fork
      spi_frame(1'b0, 15'h0010, AW + 1 + DW, q);
      begin
        waited = 0;
        while (!write_strobe && waited < 2000) begin
          @(negedge clock);
          waited++;
        end
        if (waited >= 2000) check("collide_strobe_timeout", 1, 0);
        host_address = hidx;
        host_write_data = 16'h5555;
        host_write_enable = 1'b1;
        @(negedge clock);
        host_write_enable = 1'b0;
      end
    join
    ref_mem[hidx] = 16'h5555;
    ref_mem[8'h10] = 16'hAAAA;
    host_check(8'h10);
    host_check(hidx);
  endtask

  task automatic check_reset_outputs();
    check("rst_serial_out", {31'd0, serial_out}, 0);
    check("rst_write_strobe", {31'd0, write_strobe}, 0);
    check("rst_write_address", {24'd0, write_address}, 0);
    check("rst_write_data", {16'd0, write_data}, 0);
    check("rst_frame_active", {31'd0, frame_active}, 0);
    check("rst_frame_error", {31'd0, frame_error}, 0);
    check("rst_word_count", {16'd0, word_count}, 0);
    check("rst_host_read_data", {16'd0, host_read_data}, 0);
    check("rst_state", {30'd0, debug_state}, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s0, q;
    reset = 1'b1;
    cs = 1'b1;
    sclk = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    mosi = 1'b0;
    host_address = '0;
    host_write_enable = 1'b0;
    host_write_data = '0;
    wait_cycles(5);
    check_reset_outputs();
    reset = 1'b0;

    // preload every register from the host
    for (int a = 0; a < 256; a++) begin
      host_address = 8'(a);
      host_write_data = 16'($urandom);
      host_write_enable = 1'b1;
      ref_mem[a] = host_write_data;
      @(negedge clock);
    end
    host_write_enable = 1'b0;
    host_check(8'h11);

    // mode 0 single write
    tx_words = '{16'hA5C3};
    run_write(1'b0, 1'b0, 15'h0011);
    host_check(8'h11);

    // mode 3 read
    host_write(8'h22, 16'h1234);
    run_read(1'b1, 1'b1, 15'h0022, 1);

    // mode 1 burst write wrapping the index
    tx_words = '{16'h0001, 16'h0002, 16'h0003};
    run_write(1'b0, 1'b1, 15'h00FF);
    host_check(8'hFF);
    host_check(8'h00);
    host_check(8'h01);

    // mode 2 burst read with wrap and ignored upper address bits
    host_write(8'hFF, 16'hBEEF);
    host_write(8'h00, 16'hCAFE);
    run_read(1'b1, 1'b0, 15'h7FFF, 2);

    // truncated data word after 7 bits
    set_mode(1'b0, 1'b0);
    tx_words = '{16'h1357};
    e0 = err_seen;
    s0 = strobe_seen;
    spi_frame(1'b0, 15'h0033, AW + 1 + 7, q);
    check("trunc_error_pulses", err_seen - e0, 1);
    check("trunc_no_strobe", strobe_seen - s0, 0);
    check("trunc_word_count", {16'd0, word_count}, 0);
    host_check(8'h33);

    // truncated header
    e0 = err_seen;
    spi_frame(1'b0, 15'h0033, 9, q);
    check("hdr_trunc_error_pulses", err_seen - e0, 1);

    // same-index and different-index host writes during an SPI commit
    collide(8'h10);
    collide(8'h20);

    // reset in the middle of a write frame
    set_mode(1'b0, 1'b0);
    e0 = err_seen;
    s0 = strobe_seen;
    @(negedge clock);
    cs = 1'b0;
    wait_cycles(half);
    for (int k = 0; k < 40; k++) begin
      mosi = 1'($urandom);
      wait_cycles(half);
      sclk = ~sclk;
    end
    reset = 1'b1;
    wait_cycles(3);
    check_reset_outputs();
    cs = 1'b1;
    sclk = cpol;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(8);
    check("reset_no_error", err_seen - e0, 0);
    check("reset_no_commit", strobe_seen - s0, 0);
    tx_words = '{16'h0F0F};
    run_write(1'b0, 1'b0, 15'h0044);
    host_check(8'h44);

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      logic pol, pha, rw;
      logic [AW-1:0] addr;
      int n;
      pol = 1'($urandom);
      pha = 1'($urandom);
      rw = 1'($urandom);
      addr = 15'($urandom);
      n = $urandom_range(1, 3);
      half = $urandom_range(4, 6);
      if (rw) run_read(pol, pha, addr, n);
      else begin
        tx_words.delete();
        repeat (n) tx_words.push_back(16'($urandom));
        run_write(pol, pha, addr);
        host_check(addr[7:0]);
      end
    end

    wait_cycles(20);
    check("pending_commits", exp_q.size(), 0);
    check("pending_read_words", exp_rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
